// File: rtl/timer_bank_pkg.sv
// timer_bank_pkg: register offsets, CTRL bit positions and address-map check shared by timer_bank
package timer_bank_pkg;
   localparam logic [1:0] CTRL_OFS = 2'd0;
   localparam logic [1:0] RELOAD_OFS = 2'd1;
   localparam logic [1:0] COUNT_OFS = 2'd2;
   localparam logic [1:0] STATUS_OFS = 2'd3;
   // global registers sit just above the last channel block, at 4*CHANNELS + ofs
   localparam int MS_OFS = 0;
   localparam int S_OFS = 1;
   localparam int CTRL_EN = 0;
   localparam int CTRL_PERIODIC = 1;
   localparam int CTRL_IRQ_EN = 2;
   function automatic bit map_fits(int channels, int addr_w);
      return channels >= 1 && channels <= 8 && (1 << addr_w) >= 4 * channels + 2;
   endfunction
endpackage

// File: rtl/timer_channel.sv
// timer_channel: one down-counting timer with CTRL, RELOAD, COUNT and a sticky expiry FLAG
module timer_channel
   import timer_bank_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk50mhz,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             wr_ctrl,
   input  logic             wr_reload,
   input  logic             wr_count,
   input  logic             wr_status,
   input  logic [WIDTH-1:0] wr_data,
   output logic [2:0]       ctrl,
   output logic [WIDTH-1:0] reload,
   output logic [WIDTH-1:0] count,
   output logic             flag,
   output logic             irq
);
   logic run, expire;
   logic [2:0] ctrl_nx;
   logic [WIDTH-1:0] count_nx;
   always_comb begin
      run = tick & ctrl[CTRL_EN];
      expire = run & (count <= WIDTH'(1));
      ctrl_nx = wr_ctrl ? wr_data[2:0]
              : (expire & ~ctrl[CTRL_PERIODIC]) ? (ctrl & ~(3'(1) << CTRL_EN))
              : ctrl;
      count_nx = wr_count ? wr_data
               : !run ? count
               : expire ? (ctrl[CTRL_PERIODIC] ? reload : '0)
               : count - WIDTH'(1);
   end
   always_ff @(posedge clk50mhz) begin
      if (!rst_n) begin
         ctrl <= '0;
         reload <= '0;
         count <= '0;
         flag <= 1'b0;
      end else begin
         ctrl <= ctrl_nx;
         if (wr_reload) reload <= wr_data;
         count <= count_nx;
         flag <= expire | (flag & ~(wr_status & wr_data[0]));
      end
   end
   assign irq = flag & ctrl[CTRL_IRQ_EN];
endmodule

// File: rtl/timer_bank.sv
// timer_bank: prescaled ms/s timebase plus CHANNELS register-mapped down-counting timers
module timer_bank
   import timer_bank_pkg::*;
#(
   parameter int CLK_HZ   = 50000000,
   parameter int TICK_HZ  = 1000,
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 16,
   parameter int ADDR_W   = 5
) (
   input  logic              clk50mhz,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic              wr_en,
   input  logic [WIDTH-1:0]  wr_data,
   output logic [WIDTH-1:0]  rd_data,
   output logic              irq
);
   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   localparam int SW = TICK_HZ > 1 ? $clog2(TICK_HZ) : 1;
   localparam int GBASE = 4 * CHANNELS;
   if (!map_fits(CHANNELS, ADDR_W) || TICK_HZ < 1 || TICK_DIV < 1 || TICK_DIV * TICK_HZ != CLK_HZ) begin : g_bad_params
      $error("timer_bank: inconsistent CLK_HZ/TICK_HZ/CHANNELS/ADDR_W");
   end
   logic [PW-1:0] pre;
   logic [SW-1:0] sub;
   logic [WIDTH-1:0] ms, s, rd_mux;
   logic tick, sec_wrap;
   logic [2:0] ctrl [CHANNELS];
   logic [WIDTH-1:0] reload [CHANNELS];
   logic [WIDTH-1:0] count [CHANNELS];
   logic [CHANNELS-1:0] flag, irq_v;
   assign tick = pre == PW'(TICK_DIV - 1);
   assign sec_wrap = sub == SW'(TICK_HZ - 1);
   always_ff @(posedge clk50mhz) begin
      if (!rst_n) begin
         pre <= '0;
         sub <= '0;
         ms <= '0;
         s <= '0;
         rd_data <= '0;
      end else begin
         rd_data <= rd_mux;
         pre <= tick ? '0 : pre + PW'(1);
         if (tick) begin
            ms <= ms + WIDTH'(1);
            sub <= sec_wrap ? '0 : sub + SW'(1);
            if (sec_wrap) s <= s + WIDTH'(1);
         end
      end
   end
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic sel;
      assign sel = wr_en & (addr[ADDR_W-1:2] == (ADDR_W-2)'(c));
      timer_channel #(.WIDTH(WIDTH)) u_ch (
         .clk50mhz  (clk50mhz),
         .rst_n     (rst_n),
         .tick      (tick),
         .wr_ctrl   (sel & (addr[1:0] == CTRL_OFS)),
         .wr_reload (sel & (addr[1:0] == RELOAD_OFS)),
         .wr_count  (sel & (addr[1:0] == COUNT_OFS)),
         .wr_status (sel & (addr[1:0] == STATUS_OFS)),
         .wr_data   (wr_data),
         .ctrl      (ctrl[c]),
         .reload    (reload[c]),
         .count     (count[c]),
         .flag      (flag[c]),
         .irq       (irq_v[c])
      );
   end
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < CHANNELS; i++)
         if (addr[ADDR_W-1:2] == (ADDR_W-2)'(i))
            rd_mux = addr[1:0] == CTRL_OFS ? WIDTH'(ctrl[i])
                   : addr[1:0] == RELOAD_OFS ? reload[i]
                   : addr[1:0] == COUNT_OFS ? count[i]
                   : WIDTH'(flag[i]);
      if (addr == ADDR_W'(GBASE + MS_OFS)) rd_mux = ms;
      if (addr == ADDR_W'(GBASE + S_OFS)) rd_mux = s;
   end
   assign irq = |irq_v;
endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: random + directed check of timer_bank against a behavioural register model
module tb_timer_bank;
   localparam int TICK_DIV = 10;
   localparam int TICK_HZ = 10;
   localparam int CH = 2;
   logic clk50mhz = 1'b0;
   logic rst_n = 1'b0;
   logic [4:0] addr = '0;
   logic wr_en = 1'b0;
   logic [15:0] wr_data = '0;
   logic [15:0] rd_data;
   logic irq;
   logic [2:0] addr1 = '0;
   logic wr_en1 = 1'b0;
   logic [15:0] wr_data1 = '0;
   logic [15:0] rd_data1;
   logic irq1;
   int tests = 0;
   int fails = 0;
   longint m_cyc = 0;
   bit m_valid = 1'b0;
   logic [15:0] m_rd = '0;
   bit m_en [CH], m_per [CH], m_ie [CH], m_flag [CH];
   logic [15:0] m_rel [CH], m_cnt [CH];
   bit tk, ex;
   int b;
   logic [15:0] v;

   timer_bank #(.CLK_HZ(100), .TICK_HZ(10), .CHANNELS(2), .WIDTH(16), .ADDR_W(5)) dut (
      .clk50mhz(clk50mhz), .rst_n(rst_n), .addr(addr), .wr_en(wr_en),
      .wr_data(wr_data), .rd_data(rd_data), .irq(irq));

   timer_bank #(.CLK_HZ(1), .TICK_HZ(1), .CHANNELS(1), .WIDTH(16), .ADDR_W(3)) dut1 (
      .clk50mhz(clk50mhz), .rst_n(rst_n), .addr(addr1), .wr_en(wr_en1),
      .wr_data(wr_data1), .rd_data(rd_data1), .irq(irq1));

   always #5 clk50mhz = ~clk50mhz;

   function automatic void check(string n, logic [31:0] a, logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endfunction

   // ticks completed so far = cycles since reset / TICK_DIV; ms and s follow by plain arithmetic
   function automatic logic [15:0] m_read(logic [4:0] a);
      longint t = m_cyc / TICK_DIV;
      int c = int'(a) / 4;
      if (a == 5'd8) return 16'(t);
      if (a == 5'd9) return 16'(t / TICK_HZ);
      if (a >= 5'd8) return 16'd0;
      case (a % 4)
         0: return {13'd0, m_ie[c], m_per[c], m_en[c]};
         1: return m_rel[c];
         2: return m_cnt[c];
         default: return {15'd0, m_flag[c]};
      endcase
   endfunction

   function automatic logic m_irq();
      logic r = 1'b0;
      for (int c = 0; c < CH; c++) r |= m_flag[c] & m_ie[c];
      return r;
   endfunction

   always @(posedge clk50mhz) begin
      if (!rst_n) begin
         m_cyc = 0;
         m_rd = '0;
         for (int c = 0; c < CH; c++) begin
            m_en[c] = 0; m_per[c] = 0; m_ie[c] = 0; m_flag[c] = 0;
            m_rel[c] = '0; m_cnt[c] = '0;
         end
      end else begin
         m_rd = m_read(addr);
         tk = (m_cyc % TICK_DIV) == TICK_DIV - 1;
         for (int c = 0; c < CH; c++) begin
            b = 4 * c;
            ex = 0;
            if (tk && m_en[c]) begin
               if (m_cnt[c] <= 1) begin
                  ex = 1;
                  m_cnt[c] = m_per[c] ? m_rel[c] : 16'd0;
                  if (!m_per[c]) m_en[c] = 0;
               end else m_cnt[c] = m_cnt[c] - 16'd1;
            end
            if (wr_en && int'(addr) == b) {m_ie[c], m_per[c], m_en[c]} = wr_data[2:0];
            if (wr_en && int'(addr) == b + 1) m_rel[c] = wr_data;
            if (wr_en && int'(addr) == b + 2) m_cnt[c] = wr_data;
            if (ex) m_flag[c] = 1;
            else if (wr_en && int'(addr) == b + 3 && wr_data[0]) m_flag[c] = 0;
         end
         m_cyc++;
      end
      m_valid = 1'b1;
   end

   always @(negedge clk50mhz) begin
      if (m_valid) begin
         check("rd_data", 32'(rd_data), 32'(m_rd));
         check("irq", 32'(irq), 32'(m_irq()));
      end
   end

   task automatic wr(input logic [4:0] a, input logic [15:0] d);
      addr = a; wr_data = d; wr_en = 1'b1;
      @(negedge clk50mhz);
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [15:0] r);
      addr = a; wr_en = 1'b0;
      @(negedge clk50mhz);
      r = rd_data;
   endtask

   task automatic rd1(input logic [2:0] a, output logic [15:0] r);
      addr1 = a;
      @(negedge clk50mhz);
      r = rd_data1;
   endtask

   // wait until the next clock edge is the given prescaler phase (phase 9 = tick edge)
   task automatic align(input int p);
      int n = 0;
      while (int'(m_cyc % TICK_DIV) != p && n < 40) begin
         @(negedge clk50mhz);
         n++;
      end
      if (n >= 40) begin
         tests++; fails++;
         $display("FAIL align: phase %0d not reached in 40 cycles", p);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk50mhz);
      rst_n = 1'b1;
      repeat (100) @(negedge clk50mhz);
      rd(5'd8, v); check("ms_after_100", 32'(v), 10);
      rd(5'd9, v); check("s_after_100", 32'(v), 1);
      wr(5'd8, 16'h1234);
      rd(5'd8, v); check("ms_read_only", 32'(v), 10);
      // one-shot on channel 0
      wr(5'd2, 16'd3);
      wr(5'd0, 16'd5);
      repeat (40) @(negedge clk50mhz);
      check("oneshot_irq", 32'(irq), 1);
      rd(5'd3, v); check("oneshot_flag", 32'(v), 1);
      rd(5'd2, v); check("oneshot_count", 32'(v), 0);
      rd(5'd0, v); check("oneshot_ctrl", 32'(v), 4);
      repeat (100) @(negedge clk50mhz);
      rd(5'd2, v); check("oneshot_stays", 32'(v), 0);
      wr(5'd3, 16'd1);
      check("oneshot_clear_irq", 32'(irq), 0);
      // periodic on channel 1
      wr(5'd5, 16'd2);
      wr(5'd6, 16'd2);
      wr(5'd4, 16'd7);
      repeat (25) @(negedge clk50mhz);
      check("periodic_irq", 32'(irq), 1);
      align(2);
      wr(5'd7, 16'd1);
      check("periodic_clear", 32'(irq), 0);
      repeat (25) @(negedge clk50mhz);
      check("periodic_reassert", 32'(irq), 1);
      wr(5'd5, 16'd0);
      repeat (30) @(negedge clk50mhz);
      align(9);
      wr(5'd7, 16'd1);
      rd(5'd7, v); check("clear_vs_expiry", 32'(v), 1);
      wr(5'd4, 16'd0);
      wr(5'd7, 16'd1);
      // collisions on channel 0
      wr(5'd2, 16'd50);
      wr(5'd0, 16'd1);
      align(9);
      wr(5'd2, 16'd7);
      rd(5'd2, v); check("count_write_on_tick", 32'(v), 7);
      wr(5'd2, 16'd1);
      align(9);
      wr(5'd3, 16'd1);
      rd(5'd3, v); check("status_clear_on_expiry", 32'(v), 1);
      rd(5'd0, v); check("oneshot_en_cleared", 32'(v), 0);
      wr(5'd2, 16'd1);
      wr(5'd0, 16'd1);
      align(9);
      wr(5'd0, 16'd3);
      rd(5'd0, v); check("ctrl_write_on_expiry", 32'(v), 3);
      // reset mid-run
      wr(5'd0, 16'd7); wr(5'd4, 16'd7); wr(5'd2, 16'd3); wr(5'd6, 16'd3);
      repeat (15) @(negedge clk50mhz);
      rst_n = 1'b0;
      @(negedge clk50mhz);
      rst_n = 1'b1;
      check("reset_irq", 32'(irq), 0);
      for (int a = 0; a < 10; a++) begin
         rd(5'(a), v); check("reset_reg", 32'(v), 0);
      end
      rst_n = 1'b0;
      @(negedge clk50mhz);
      rst_n = 1'b1;
      repeat (9) @(negedge clk50mhz);
      rd(5'd8, v); check("first_tick_before", 32'(v), 0);
      rd(5'd8, v); check("first_tick_after", 32'(v), 1);
      // randomized traffic, checked every cycle by the compare process
      for (int i = 0; i < 3000; i++) begin
         rst_n = $urandom_range(0, 399) != 0;
         addr = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 11));
         wr_en = $urandom_range(0, 2) == 0;
         wr_data = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 5)) : 16'($urandom);
         @(negedge clk50mhz);
      end
      rst_n = 1'b1;
      wr_en = 1'b0;
      // wrap with one tick per clock
      rst_n = 1'b0;
      @(negedge clk50mhz);
      rst_n = 1'b1;
      repeat (3) @(negedge clk50mhz);
      rd1(3'd4, v); check("fast_ms", 32'(v), 3);
      rd1(3'd5, v); check("fast_s", 32'(v), 4);
      repeat (65531) @(negedge clk50mhz);
      rd1(3'd4, v); check("ms_wrap", 32'(v), 0);
      rd1(3'd5, v); check("s_wrap", 32'(v), 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/timer_bank.md
# timer_bank

Parametrised multi-channel timer peripheral for the SCP IO space, clocked from the 50 MHz board clock. It provides a free-running millisecond and second timebase derived from an exact prescaler. It also provides CHANNELS independent down-counting timers, each with one-shot or periodic mode, a sticky expiry flag and an interrupt enable. The CPU accesses all state through a simple synchronous register port, and the block drives one OR-ed interrupt line to the interrupt controller.

## Interface
- CLK_HZ, 50000000, input clock frequency.
- TICK_HZ, 1000, tick rate. TICK_DIV = CLK_HZ/TICK_HZ must be an integer ≥1, and TICK_HZ ≥1.
- CHANNELS, 4, number of timer channels, 1..8.
- WIDTH, 16, width of counters and data bus.
- ADDR_W, 5, address width; must satisfy 2^ADDR_W ≥ 4·CHANNELS+2.
- clk50mhz  in  1  system clock; everything is on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- addr  in  ADDR_W  register address.
- wr_en  in  1  write strobe, one cycle per write.
- wr_data  in  WIDTH  write data.
- rd_data  out  WIDTH  registered read data.
- irq  out  1  interrupt request, level.

## Operation
- **Prescaler**: a counter runs 0..TICK_DIV-1 and then wraps. `tick` is a one-cycle internal pulse in the cycle the counter equals TICK_DIV-1.
- **Timebase**
  - `ms` (WIDTH bits) increments on every tick and wraps 2^WIDTH-1→0.
  - A sub-counter counts ticks 0..TICK_HZ-1. When it wraps, `s` (WIDTH bits) increments and wraps.
  - `ms` and `s` are read-only.
- **Register map**, for channel c at base 4c:
  - +0 CTRL: bit0 EN, bit1 PERIODIC, bit2 IRQ_EN; other bits read 0.
  - +1 RELOAD.
  - +2 COUNT: a write loads the count directly.
  - +3 STATUS: bit0 FLAG; writing 1 to bit0 clears it, writing 0 has no effect.
- **Global registers**: 4·CHANNELS is MS, 4·CHANNELS+1 is S. Unmapped addresses read 0 and ignore writes.
- **Channel, on a tick with EN=1**
  - If count ≤1, the channel expires: FLAG←1.
    - PERIODIC=1: count←RELOAD.
    - PERIODIC=0: count←0 and EN←0.
  - Otherwise count←count-1.
  - Effective period is max(RELOAD,1) ticks; RELOAD=0 in periodic mode expires every tick.
- Setting EN does not alter the count. Software loads COUNT before enabling.
- **Simultaneous events**
  - A COUNT or CTRL write in a tick cycle takes priority over the tick update, for that channel's written field only.
  - A STATUS clear in the same cycle as an expiry leaves FLAG=1, because set wins.
  - An expiry with a concurrent CTRL write keeps the written CTRL value, including EN.
- irq = OR over channels of (FLAG & IRQ_EN), combinational from registers.

## Timing
- **Reset**: while rst_n=0 at a clock edge, the following all clear to 0: prescaler, tick sub-counter, ms, s, every CTRL/RELOAD/COUNT/FLAG, rd_data. irq is therefore 0 from the cycle after reset.
- After reset release, the first tick occurs in the TICK_DIV-th cycle.
- Reset asserted mid-operation aborts all channels; there is no partial state.
- **Read latency 1**: the addr presented at edge N appears on rd_data after edge N. It carries the register value from before any write or tick update at edge N. rd_data holds its value until the next edge.
- A write takes effect at the edge where wr_en=1 and is visible to a read issued on the next cycle.
- FLAG and irq rise in the cycle after the expiring tick edge. After a STATUS clear, irq falls in the cycle after the clearing edge.

## Structure
- Shared package `timer_bank_pkg`:
  - register offsets (CTRL=0, RELOAD=1, COUNT=2, STATUS=3, MS_OFS, S_OFS);
  - CTRL bit indices;
  - a CHANNELS/ADDR_W consistency-check function.
- One sub-module, `timer_channel`, instantiated CHANNELS times. It holds CTRL, RELOAD, COUNT and FLAG, takes tick plus decoded per-register write enables, and outputs its register values and irq contribution.
- The top level holds the prescaler, timebase, address decode, read mux and irq OR.

## Test plan
Use CLK_HZ=100, TICK_HZ=10 (TICK_DIV=10), CHANNELS=2 unless noted.
- **Free-running timebase**: reset, then run 100 cycles → ms=10, s=1, read back at MS/S addresses with 1-cycle latency. A write to MS is ignored.
- **One-shot**: write COUNT0=3, then CTRL0=0b101. FLAG0 and irq rise after the 3rd tick, count=0 and EN=0, and no further expiry occurs over 10 ticks.
- **Periodic and clear**: RELOAD1=2, COUNT1=2, CTRL1=0b111 → expiry every 2 ticks. Writing STATUS1=1 drops irq the next cycle; it re-asserts at the next expiry. With RELOAD1=0, the channel expires every tick.
- **Collisions**: STATUS0 clear on the expiry edge leaves FLAG0=1. A COUNT0=7 write on a tick edge reads back 7, not 6.
- **Reset mid-run**: rst_n=0 for 1 cycle with both channels active → all registers read 0 and irq=0. The first tick lands 10 cycles after release.
- **Wrap**: with CLK_HZ=TICK_HZ=1, after 65536 ticks ms wraps to 0, and s increments every tick.
